// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronises the raw pad, debounces each
// transition and produces a clean pressed level plus press/release/long strobes.
//
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous, active-high reset
//   btn_i     raw button pad, asynchronous to clk_i
//   btn_o     debounced level, 1 = pressed
//   press_o   one-cycle strobe on accepted press
//   release_o one-cycle strobe on accepted release
//   long_o    one-cycle strobe when a hold reaches LONG_CYCLES
//   held_o    level, 1 from long_o until the accepted release
module btn_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 250_000,
   parameter int LONG_CYCLES     = 25_000_000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic btn_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic held_o
);

   generate
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("btn_debounce: SYNC_STAGES must be >= 2");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
         $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
      end
      if (LONG_CYCLES < 1) begin : g_bad_long
         $error("btn_debounce: LONG_CYCLES must be >= 1");
      end
   endgenerate

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   // Pad level while the button is not pressed.
   localparam logic IDLE_LVL = ACTIVE_LOW;

   typedef enum logic [1:0] {
      S_RELEASED,
      S_PRESS_WAIT,
      S_PRESSED,
      S_RELEASE_WAIT
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
   logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
   logic                   btn_q, btn_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_q, long_d;
   logic                   held_q, held_d;
   logic                   p_s;

   // Polarity-normalised synchronised level, 1 = pressed.
   assign p_s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], btn_i};
      state_d    = state_q;
      deb_cnt_d  = deb_cnt_q;
      hold_cnt_d = hold_cnt_q;
      btn_d      = btn_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      held_d     = held_q;

      unique case (state_q)
         S_RELEASED: begin
            if (p_s) begin
               state_d   = S_PRESS_WAIT;
               deb_cnt_d = '0;
            end
         end

         S_PRESS_WAIT: begin
            if (!p_s) begin
               state_d = S_RELEASED;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d    = S_PRESSED;
               btn_d      = 1'b1;
               press_d    = 1'b1;
               hold_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DW'(1);
            end
         end

         S_PRESSED: begin
            // The hold counter saturates at its last value so long_o
            // cannot fire again for the same press.
            if (hold_cnt_q == HOLD_LAST) begin
               if (!held_q) begin
                  long_d = 1'b1;
                  held_d = 1'b1;
               end
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
            if (!p_s) begin
               state_d   = S_RELEASE_WAIT;
               deb_cnt_d = '0;
            end
         end

         S_RELEASE_WAIT: begin
            // hold_cnt is frozen here; a rejected bounce resumes it.
            if (p_s) begin
               state_d = S_PRESSED;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d    = S_RELEASED;
               btn_d      = 1'b0;
               held_d     = 1'b0;
               release_d  = 1'b1;
               hold_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DW'(1);
            end
         end

         default: state_d = S_RELEASED;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q     <= {SYNC_STAGES{IDLE_LVL}};
         state_q    <= S_RELEASED;
         deb_cnt_q  <= '0;
         hold_cnt_q <= '0;
         btn_q      <= 1'b0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         state_q    <= state_d;
         deb_cnt_q  <= deb_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         btn_q      <= btn_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         held_q     <= held_d;
      end
   end

   assign btn_o     = btn_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign long_o    = long_q;
   assign held_o    = held_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: strobe timing is checked against a
// scoreboard of expected (kind, edge) events, levels by direct checks.
module tb_btn_debounce;

   localparam int K_PRESS   = 0;
   localparam int K_RELEASE = 1;
   localparam int K_LONG    = 2;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_a = 1'b1;
   logic btn_b = 1'b0;

   logic lvl_a, press_a, rel_a, long_a, held_a;
   logic lvl_b, press_b, rel_b, long_b, held_b;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int c;

   ev_t qa[$];
   ev_t qb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   btn_debounce #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
      .LONG_CYCLES(32), .ACTIVE_LOW(1'b1)
   ) u_a (
      .clk_i(clk), .rst_i(rst), .btn_i(btn_a),
      .btn_o(lvl_a), .press_o(press_a), .release_o(rel_a),
      .long_o(long_a), .held_o(held_a)
   );

   btn_debounce #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8),
      .LONG_CYCLES(32), .ACTIVE_LOW(1'b0)
   ) u_b (
      .clk_i(clk), .rst_i(rst), .btn_i(btn_b),
      .btn_o(lvl_b), .press_o(press_b), .release_o(rel_b),
      .long_o(long_b), .held_o(held_b)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(int d, int kind, int at);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
   endtask

   task automatic mon(int d, logic p, logic r, logic l);
      logic [2:0] s;
      ev_t e;
      s = {l, r, p};
      if (s != 3'b000)
         chk("strobe_excl", {31'd0, (p & r) | (p & l)}, 0);
      for (int k = 0; k < 3; k++) begin
         if (s[k]) begin
            e.kind = -1;
            e.cyc  = -1;
            if (d == 0 && qa.size() > 0) e = qa.pop_front();
            if (d == 1 && qb.size() > 0) e = qb.pop_front();
            chk(d == 0 ? "a_kind" : "b_kind", k, e.kind);
            chk(d == 0 ? "a_edge" : "b_edge", cyc, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, press_a, rel_a, long_a);
         mon(1, press_b, rel_b, long_b);
      end
   end

   task automatic wait_n(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1 rst = 1'b1;
      wait_n(3);
      chk("rst_a_btn",  lvl_a, 0);
      chk("rst_a_held", held_a, 0);
      chk("rst_a_strb", {press_a, rel_a, long_a}, 0);
      chk("rst_b_btn",  lvl_b, 0);
      chk("rst_b_strb", {press_b, rel_b, long_b}, 0);
      rst = 1'b0;
      wait_n(5);
      chk("idle_b_btn", lvl_b, 0);

      // 1: clean press with long hold
      btn_a = 1'b0;
      c = cyc;
      push(0, K_PRESS, c + 11);
      push(0, K_LONG, c + 43);
      wait_n(20);
      chk("t1_btn_mid", lvl_a, 1);
      chk("t1_held_mid", held_a, 0);
      wait_n(40);
      chk("t1_btn", lvl_a, 1);
      chk("t1_held", held_a, 1);
      btn_a = 1'b1;
      c = cyc;
      push(0, K_RELEASE, c + 11);
      wait_n(5);
      chk("t1_btn_rw", lvl_a, 1);
      wait_n(10);
      chk("t1_btn_rel", lvl_a, 0);
      chk("t1_held_rel", held_a, 0);

      // 2: press bounce rejected
      btn_a = 1'b0;
      wait_n(5);
      btn_a = 1'b1;
      wait_n(3);
      btn_a = 1'b0;
      wait_n(5);
      btn_a = 1'b1;
      wait_n(20);
      chk("t2_btn", lvl_a, 0);

      // 3: release bounce delays long_o by the RELEASE_WAIT cycles
      btn_a = 1'b0;
      c = cyc;
      push(0, K_PRESS, c + 11);
      wait_n(20);
      btn_a = 1'b1;
      push(0, K_LONG, c + 47);
      wait_n(4);
      btn_a = 1'b0;
      wait_n(20);
      chk("t3_btn", lvl_a, 1);
      chk("t3_held_pre", held_a, 0);
      wait_n(16);
      chk("t3_held", held_a, 1);
      btn_a = 1'b1;
      c = cyc;
      push(0, K_RELEASE, c + 11);
      wait_n(15);
      chk("t3_btn_rel", lvl_a, 0);

      // 4: short press, no long
      btn_a = 1'b0;
      c = cyc;
      push(0, K_PRESS, c + 11);
      wait_n(20);
      chk("t4_btn", lvl_a, 1);
      chk("t4_held", held_a, 0);
      btn_a = 1'b1;
      c = cyc;
      push(0, K_RELEASE, c + 11);
      wait_n(40);
      chk("t4_btn_rel", lvl_a, 0);
      chk("t4_held_rel", held_a, 0);

      // 5: reset mid-hold
      btn_a = 1'b0;
      c = cyc;
      push(0, K_PRESS, c + 11);
      push(0, K_LONG, c + 43);
      wait_n(50);
      chk("t5_held_pre", held_a, 1);
      rst = 1'b1;
      #1;
      chk("t5_rst_btn", lvl_a, 0);
      chk("t5_rst_held", held_a, 0);
      chk("t5_rst_strb", {press_a, rel_a, long_a}, 0);
      wait_n(3);
      rst = 1'b0;
      c = cyc;
      push(0, K_PRESS, c + 11);
      push(0, K_LONG, c + 43);
      wait_n(50);
      chk("t5_btn", lvl_a, 1);
      chk("t5_held", held_a, 1);
      btn_a = 1'b1;
      c = cyc;
      push(0, K_RELEASE, c + 11);
      wait_n(15);
      chk("t5_btn_rel", lvl_a, 0);

      // 6: active-high pad instance
      btn_b = 1'b1;
      c = cyc;
      push(1, K_PRESS, c + 11);
      wait_n(20);
      chk("t6_btn", lvl_b, 1);
      chk("t6_held", held_b, 0);
      btn_b = 1'b0;
      c = cyc;
      push(1, K_RELEASE, c + 11);
      wait_n(15);
      chk("t6_btn_rel", lvl_b, 0);

      wait_n(5);
      chk("sb_a_left", qa.size(), 0);
      chk("sb_b_left", qb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Conditions the raw user push-button pad before it reaches the LED pattern logic. It synchronises the asynchronous pad input and debounces it with a per-transition stability counter. It produces a clean pressed level, single-cycle press/release strobes and a long-press strobe. It sits between the board button pin and the consumers of the button (LED blink/pattern blocks), replacing direct use of the raw pin.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchroniser; must be >= 2
DEBOUNCE_CYCLES, 250_000, cycles the synchronised input must be stable before a transition is accepted (10 ms at 25 MHz); must be >= 1
LONG_CYCLES, 25_000_000, cycles in PRESSED before long_o fires (1 s at 25 MHz); must be >= 1
ACTIVE_LOW, 1, 1: pad reads 0 when pressed; 0: pad reads 1 when pressed

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
btn_i  input  1  raw button pad, asynchronous to clk_i
btn_o  output 1  debounced level, 1 = pressed (polarity-normalised)
press_o  output 1  one-cycle strobe on accepted press
release_o  output 1  one-cycle strobe on accepted release
long_o  output 1  one-cycle strobe when hold reaches LONG_CYCLES
held_o  output 1  level, 1 from long_o until accepted release

Behaviour:
- Any parameter out of range is an elaboration error.
- Reset (async assert, clears immediately):
  - Synchroniser flops load the released pad level (1 if ACTIVE_LOW, else 0).
  - State = RELEASED; both counters = 0.
  - btn_o, press_o, release_o, long_o, held_o = 0.
- Synchroniser: SYNC_STAGES flops in series. The last stage XOR polarity gives p_s (1 = pressed). There is no other use of btn_i.
- Debounce counter width = clog2(DEBOUNCE_CYCLES+1). Hold counter width = clog2(LONG_CYCLES+1).
- States:
  - RELEASED:
    - p_s=1 -> PRESS_WAIT, deb_cnt<=0.
  - PRESS_WAIT:
    - p_s=0 -> RELEASED (bounce rejected, no strobe).
    - Else if deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED: btn_o<=1, press_o<=1 for one cycle, hold_cnt<=0.
    - Else deb_cnt++.
  - PRESSED:
    - If hold_cnt==LONG_CYCLES-1 and held_o==0: long_o<=1 for one cycle, held_o<=1. hold_cnt saturates (stops incrementing).
    - Otherwise hold_cnt++ each cycle.
    - p_s=0 -> RELEASE_WAIT, deb_cnt<=0; hold_cnt frozen.
    - A p_s=0 and long-press event in the same cycle is legal: long_o still fires, then enter RELEASE_WAIT.
  - RELEASE_WAIT:
    - p_s=1 -> PRESSED (bounce rejected; hold_cnt resumes from its frozen value, btn_o stays 1, no press_o).
    - Else if deb_cnt==DEBOUNCE_CYCLES-1 -> RELEASED: btn_o<=0, held_o<=0, release_o<=1 for one cycle, hold_cnt<=0.
    - Else deb_cnt++.
- All outputs are registered.
  - press_o rises on the same edge as btn_o rises.
  - release_o rises on the same edge as btn_o falls.
- Latency from the first edge sampling a stable pressed pad to the edge raising btn_o/press_o: SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges. Release latency is identical.
- long_o rises exactly LONG_CYCLES edges after press_o rises, provided no RELEASE_WAIT excursion occurs; excursions add their duration.
- Strobe exclusivity:
  - press_o and release_o never coincide.
  - long_o never coincides with press_o.
  - long_o fires at most once per accepted press.
- Reset mid-operation: returns to RELEASED with no release_o strobe. If the button is still held after reset deasserts, a normal full-latency press_o follows.

Test Plan:
(Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1.)
1. Clean press: btn_i 1->0 held 60 cycles, then 0->1 -> press_o single pulse exactly 11 edges after the first 0 sample. btn_o=1 until release_o, which pulses 11 edges after the first 1 sample. long_o pulses 32 edges after press_o; held_o=1 from then until release.
2. Press bounce: btn_i low for 5 cycles, high for 3, low for 5, high -> no press_o, btn_o stays 0, state returns to RELEASED.
3. Release bounce: while pressed, btn_i high for 4 cycles, then low for 20 -> no release_o, btn_o stays 1. long_o is delayed by exactly the RELEASE_WAIT cycles spent.
4. Short press: stable low for 20 cycles then release -> press_o and release_o each pulse once, long_o and held_o never assert.
5. Reset mid-hold: assert rst_i after long_o with the button still held, release rst_i -> all outputs 0 immediately, no release_o. press_o pulses 11 edges after reset deassertion; long_o fires again 32 edges later.
6. ACTIVE_LOW=0 instance: btn_i 0->1 for 20 cycles -> press_o after 11 edges, btn_o=1. btn_i=0 at reset gives btn_o=0 with no spurious strobes.
